// File: rtl/wait_event_arbiter.sv
// Round-robin arbiter sharing one wait-event checker among NB_REQ command sources.
// Launches the granted command, adds a cycle watchdog, and returns per-requester done/error.
module wait_event_arbiter #(
    parameter  int NB_REQ    = 4,
    parameter  int WAIT_SIZE = 5,
    parameter  int WD_MARGIN = 16,
    localparam int IDX_W     = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NB_REQ-1:0]         i_req,
    input  logic [NB_REQ-1:0]         i_sel_wtr_wtf,
    input  logic [NB_REQ*IDX_W-1:0]   i_wait_idx,
    input  logic [NB_REQ*32-1:0]      i_timeout,
    output logic [NB_REQ-1:0]         o_gnt,
    output logic [NB_REQ-1:0]         o_done,
    output logic                      o_err,
    output logic                      o_en_wait_event,
    output logic [31:0]               o_wait_en,
    output logic                      o_sel_wtr_wtf,
    output logic [31:0]               o_max_timeout,
    input  logic                      i_wait_done,
    output logic                      o_busy
);

    localparam int PTR_W = $clog2(NB_REQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    r_winner;
    logic [32:0]         r_counter;
    logic                r_err;
    logic [31:0]         r_wait_en;
    logic                r_sel;
    logic [31:0]         r_max_timeout;

    logic                w_any_req;
    logic [PTR_W-1:0]    w_pick;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_sel;
    logic [31:0]         w_pick_tmo;
    logic [NB_REQ-1:0]   w_onehot;
    logic [32:0]         w_wd_limit;
    logic                w_wd_hit;

    // First pending requester at or after r_rr_ptr, wrapping modulo NB_REQ.
    always_comb begin
        w_any_req = 1'b0;
        w_pick    = '0;
        for (int unsigned off = 0; off < NB_REQ; off++) begin
            for (int unsigned c = 0; c < NB_REQ; c++) begin
                if (!w_any_req && i_req[c] &&
                    (c == (32'(r_rr_ptr) + off) % 32'(NB_REQ))) begin
                    w_any_req = 1'b1;
                    w_pick    = PTR_W'(c);
                end
            end
        end
    end

    always_comb begin
        w_pick_idx = '0;
        w_pick_sel = 1'b0;
        w_pick_tmo = '0;
        for (int unsigned r = 0; r < NB_REQ; r++) begin
            if (32'(w_pick) == r) begin
                w_pick_idx = i_wait_idx[r*IDX_W +: IDX_W];
                w_pick_sel = i_sel_wtr_wtf[r];
                w_pick_tmo = i_timeout[r*32 +: 32];
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int unsigned c = 0; c < NB_REQ; c++) begin
            w_onehot[c] = (32'(r_winner) == c);
        end
    end

    assign w_wd_limit = {1'b0, r_max_timeout} + 33'(WD_MARGIN);
    assign w_wd_hit   = (r_counter == w_wd_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        o_gnt           = '0;
        o_done          = '0;
        o_err           = 1'b0;
        o_en_wait_event = 1'b0;
        o_busy          = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (w_any_req) begin
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                o_gnt           = w_onehot;
                o_en_wait_event = 1'b1;
                w_state_nxt     = ST_WAIT;
            end
            ST_WAIT: begin
                o_gnt = w_onehot;
                if (i_wait_done || w_wd_hit) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                o_gnt       = w_onehot;
                o_done      = w_onehot;
                o_err       = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_winner      <= '0;
            r_counter     <= '0;
            r_err         <= 1'b0;
            r_wait_en     <= '0;
            r_sel         <= 1'b0;
            r_max_timeout <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_winner      <= w_pick;
                        r_wait_en     <= 32'(w_pick_idx);
                        r_sel         <= w_pick_sel;
                        r_max_timeout <= w_pick_tmo;
                    end
                end
                ST_LAUNCH: begin
                    r_counter <= '0;
                    r_err     <= 1'b0;
                end
                ST_WAIT: begin
                    if (r_counter != '1) begin
                        r_counter <= r_counter + 33'd1;
                    end
                    // Checker completion takes priority over a coincident watchdog hit.
                    if (i_wait_done) begin
                        r_err <= 1'b0;
                    end else if (w_wd_hit) begin
                        r_err <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_rr_ptr <= (32'(r_winner) == 32'(NB_REQ - 1)) ? '0 : r_winner + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_wait_en     = r_wait_en;
    assign o_sel_wtr_wtf = r_sel;
    assign o_max_timeout = r_max_timeout;

endmodule

// File: doc/wait_event_arbiter.md
Name: wait_event_arbiter

Overview:
- Shares one wait-event checker instance between NB_REQ testbench command sources.
- Each requester posts a wait command: event index, rising/falling select, and timeout.
- The block grants requesters round-robin, launches the command on the checker, and tracks completion.
- It applies a cycle watchdog on top of the checker's own timeout and returns a per-requester done/error pulse.
- Sits between the scenario command decoders and the wait-event checker.

Parameters:
- NB_REQ, 4, number of requesters (2..8).
- WAIT_SIZE, 5, number of selectable wait signals; index width IDX_W = $clog2(WAIT_SIZE).
- WD_MARGIN, 16, extra cycles added to the posted timeout before the watchdog fires.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  NB_REQ  level request per requester; held high until its o_done.
- i_sel_wtr_wtf  in  NB_REQ  per requester: 1 = wait rising, 0 = wait falling.
- i_wait_idx  in  NB_REQ*IDX_W  per-requester event index, requester r at bits [r*IDX_W +: IDX_W].
- i_timeout  in  NB_REQ*32  per-requester timeout in cycles, requester r at bits [r*32 +: 32].
- o_gnt  out  NB_REQ  one-hot; the owner from LAUNCH through RESP.
- o_done  out  NB_REQ  one-cycle pulse to the owner on completion.
- o_err  out  1  valid with o_done: 1 = watchdog expired, 0 = checker completed.
- o_en_wait_event  out  1  one-cycle launch strobe to the checker.
- o_wait_en  out  32  event index, zero-extended.
- o_sel_wtr_wtf  out  1  edge select to the checker.
- o_max_timeout  out  32  timeout to the checker.
- i_wait_done  in  1  checker completion.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; rr_ptr = 0; counter = 0. Reset mid-operation aborts immediately and issues no o_done.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE
  - If any i_req is high, choose the winner: the first set bit scanning from rr_ptr upward, modulo NB_REQ.
  - Register the winner's sel, idx and timeout into the o_* command registers, then go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH
  - o_en_wait_event = 1 for exactly this cycle; o_gnt = one-hot winner; counter cleared to 0.
  - i_wait_done is ignored in this cycle.
  - Go to WAIT.
- WAIT
  - counter increments each cycle and saturates at all-ones (33 bits).
  - If i_wait_done = 1: err_q = 0, go to RESP.
  - Else if counter == {1'b0, o_max_timeout} + WD_MARGIN (33-bit compare): err_q = 0→1, go to RESP.
  - If both conditions hold in the same cycle, i_wait_done wins and err = 0.
- RESP
  - o_done[winner] = 1 and o_err = err_q for one cycle.
  - rr_ptr = winner + 1, wrapping to 0 after NB_REQ-1.
  - Go to IDLE; o_gnt clears in the next cycle.
- Latency: the request is sampled in IDLE at cycle k, the launch strobe appears at k+1, and o_done appears one cycle after the terminating condition. Minimum request-to-done is 4 cycles.
- Back-to-back: a request still high after its done is re-arbitrated normally. Because of the rr_ptr rotation, another pending requester is served first.
- The command registers stay stable from LAUNCH until the next IDLE grant.
- Changes on the owner's i_* fields after the grant are ignored.
- A requester dropping i_req during WAIT does not abort the operation; o_done is still pulsed.
- i_wait_done outside WAIT is ignored.
- i_timeout = 0: the watchdog fires after WD_MARGIN WAIT cycles.
- Indices >= WAIT_SIZE are passed through unchanged; range checking is the checker's responsibility.

Test Plan:
- Single request, r=1, idx=2, sel=1, timeout=100; i_wait_done 10 cycles after the strobe → one strobe; o_wait_en = 2; o_done[1] one cycle after done; o_err = 0; o_gnt = 4'b0010 throughout.
- All 4 requesters held high, each completing quickly → grant order 0, 1, 2, 3, 0; each o_done pulses exactly once per grant.
- timeout=20, WD_MARGIN=16, no i_wait_done → o_done with o_err = 1 exactly 36 WAIT cycles after LAUNCH.
- i_wait_done asserted in the same cycle the watchdog limit is reached → o_err = 0.
- rst asserted during WAIT → all outputs 0 asynchronously; no o_done; next request is granted from rr_ptr = 0.
- i_wait_done pulsed while in IDLE and during the LAUNCH cycle → no state change; the operation completes only on a later done in WAIT.
